// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer feeding the execution controller
// Fetches 16-bit words, latches IR, pulses start, retires on waiting; detects HALT and exec timeout.
module fetch_sequencer #(
  parameter int PC_W         = 8,
  parameter int RESET_PC     = 0,
  parameter int EXEC_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_rdy,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     ir,
  output logic            start,
  input  logic            waiting,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instr_count,
  output logic            halted,
  output logic            err
);

  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_START,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_count;
  logic              r_err;
  logic [CNT_W-1:0]  r_exec_cnt;
  logic              w_retire;
  logic              w_timeout;
  logic              w_mem_rd;
  logic              w_start;
  logic              w_halted;

  // r_exec_cnt holds the number of EXEC cycles already completed, so zero marks
  // the first EXEC cycle, where the controller has not yet dropped waiting.
  assign w_retire  = (r_state == S_EXEC) && (r_exec_cnt != '0) && waiting;
  assign w_timeout = (r_state == S_EXEC) && !w_retire &&
                     (r_exec_cnt == CNT_W'(EXEC_TIMEOUT - 1));

  always_comb begin
    w_next   = r_state;
    w_mem_rd = 1'b0;
    w_start  = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_rd = 1'b1;
        if (mem_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = (r_ir[15:13] == 3'b111) ? S_HALT : S_START;
      end
      S_START: begin
        w_start = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        if (w_retire)       w_next = run ? S_FETCH : S_IDLE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_W'(RESET_PC);
      r_ir       <= 16'h0000;
      r_count    <= 16'h0000;
      r_err      <= 1'b0;
      r_exec_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && mem_rdy) begin
        r_ir <= mem_rdata;
        r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == S_START) r_exec_cnt <= '0;
      else if (r_state == S_EXEC) r_exec_cnt <= r_exec_cnt + CNT_W'(1);
      if (w_retire && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign mem_rd      = w_mem_rd;
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign start       = w_start;
  assign halted      = w_halted;
  assign instr_count = r_count;
  assign err         = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int PC_W = 8;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rdy;
  logic [15:0]     mem_rdata;
  logic [15:0]     ir;
  logic            start;
  logic            waiting;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr_count;
  logic            halted;
  logic            err;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(PC_W), .RESET_PC(0), .EXEC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .ir(ir), .start(start), .waiting(waiting), .pc(pc),
    .instr_count(instr_count), .halted(halted), .err(err)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:255];
  int          wait_tab [0:511];
  int          busy_tab [0:511];
  bit          hang;

  bit          rd_active;
  int          wait_left;
  int          fidx, sidx, ecyc, start_cnt;
  bit          ir_pend;
  logic [15:0] ir_exp;
  logic [7:0]  fetch_log [$];
  bit          rd_seen, start_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory and execution-controller models, evaluated on the falling edge.
  task automatic respond();
    if (ir_pend) begin
      chk("ir_latch", {16'h0, ir}, {16'h0, ir_exp});
      ir_pend = 1'b0;
    end
    if (mem_rd) rd_seen = 1'b1;
    if (start)  start_seen = 1'b1;
    if (mem_rd) begin
      if (!rd_active) begin
        rd_active = 1'b1;
        wait_left = wait_tab[fidx % 512];
        fetch_log.push_back(mem_addr);
      end
      if (wait_left > 0) begin
        mem_rdy   = 1'b0;
        mem_rdata = 16'($urandom);
        wait_left--;
      end else begin
        mem_rdy   = 1'b1;
        mem_rdata = mem[mem_addr];
        ir_exp    = mem[mem_addr];
        ir_pend   = 1'b1;
        rd_active = 1'b0;
        fidx++;
      end
    end else begin
      mem_rdy   = 1'($urandom);
      mem_rdata = 16'($urandom);
    end
    // Controller still shows waiting on the first busy cycle, then drops it.
    if (ecyc > 0) begin
      if (hang) waiting = (ecyc == 1);
      else      waiting = (ecyc == 1) || (ecyc >= 2 + busy_tab[(sidx - 1) % 512]);
      if ((ecyc >= 2 && waiting) || ecyc >= TMO) ecyc = 0;
      else ecyc++;
    end else begin
      waiting = 1'b1;
    end
    if (start) begin
      start_cnt++;
      sidx++;
      ecyc = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    respond();
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 512; i++) begin
      wait_tab[i] = 0;
      busy_tab[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst        = 1'b0;
    rd_active  = 1'b0;
    wait_left  = 0;
    fidx       = 0;
    sidx       = 0;
    ecyc       = 0;
    start_cnt  = 0;
    ir_pend    = 1'b0;
    hang       = 1'b0;
    waiting    = 1'b1;
    mem_rdy    = 1'b0;
    fetch_log.delete();
  endtask

  task automatic wait_halted(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_pc"},     pc, 0);
    chk({pfx, "_addr"},   mem_addr, 0);
    chk({pfx, "_ir"},     ir, 0);
    chk({pfx, "_rd"},     mem_rd, 0);
    chk({pfx, "_start"},  start, 0);
    chk({pfx, "_halted"}, halted, 0);
    chk({pfx, "_err"},    err, 0);
    chk({pfx, "_count"},  instr_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_cyc;
    int n_ins;
    bit ok;
    bit found;
    logic [15:0] w;

    rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; mem_rdata = 16'h0; waiting = 1'b1; hang = 1'b0;

    // Reset and idle hold
    clear_env();
    do_reset();
    chk_reset_values("rst");
    rd_seen = 1'b0; start_seen = 1'b0;
    repeat (10) tick();
    chk("idle_no_rd", rd_seen, 0);
    chk("idle_no_start", start_seen, 0);

    // Zero-wait fetch and execute, controller busy 2 cycles
    clear_env();
    mem[0] = 16'hD123; mem[1] = 16'hE000; busy_tab[0] = 2;
    do_reset();
    run = 1'b1;
    tick();
    chk("z_rd", mem_rd, 1);
    chk("z_addr", mem_addr, 0);
    tick();
    chk("z_ir", ir, 16'hD123);
    chk("z_pc", pc, 1);
    chk("z_start_low", start, 0);
    tick();
    chk("z_start", start, 1);
    n = 0;
    while (!mem_rd && n < 20) begin
      tick();
      n++;
    end
    chk("z_period", n, 5);
    chk("z_count", instr_count, 1);
    chk("z_addr1", mem_addr, 1);
    wait_halted(20, n);
    chk("z_halt", halted, 1);
    chk("z_starts", start_cnt, 1);

    // Memory wait states
    clear_env();
    mem[0] = 16'h6000; mem[1] = 16'hE000; wait_tab[0] = 3;
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws_hold%0d", i), {7'h0, mem_rd, mem_addr, ir}, {7'h0, 1'b1, 8'h00, 16'h0000});
      if (i < 3) tick();
    end
    tick();
    chk("ws_ir", ir, 16'h6000);
    chk("ws_rd_low", mem_rd, 0);
    wait_halted(40, n);
    chk("ws_pc", pc, 2);
    chk("ws_count", instr_count, 1);

    // HALT opcode
    clear_env();
    mem[0] = 16'h6000; mem[1] = 16'h6000; mem[2] = 16'hE000;
    do_reset();
    run = 1'b1;
    wait_halted(100, n);
    chk("h_halted", halted, 1);
    chk("h_starts", start_cnt, 2);
    chk("h_pc", pc, 3);
    chk("h_count", instr_count, 2);
    chk("h_err", err, 0);
    rd_seen = 1'b0; start_seen = 1'b0;
    repeat (20) tick();
    chk("h_no_rd", rd_seen, 0);
    chk("h_no_start", start_seen, 0);
    chk("h_still", halted, 1);

    // Pause during EXEC of 8'hFF, pc wraps, resume at 0
    clear_env();
    do_reset();
    run = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < 3000) begin
      tick();
      n++;
      if (start && fetch_log.size() == 256) begin
        found = 1'b1;
        break;
      end
    end
    chk("w_found", found, 1);
    tick();
    run = 1'b0;
    tick();
    rd_seen = 1'b0;
    repeat (10) tick();
    chk("w_no_rd", rd_seen, 0);
    chk("w_pc", pc, 0);
    chk("w_count", instr_count, 256);
    chk("w_last", fetch_log[fetch_log.size() - 1], 8'hFF);
    run = 1'b1;
    n = 0;
    while (!mem_rd && n < 5) begin
      tick();
      n++;
    end
    chk("w_resume_rd", mem_rd, 1);
    chk("w_resume_addr", mem_addr, 0);

    // Execution timeout
    clear_env();
    mem[0] = 16'h1234;
    do_reset();
    hang = 1'b1;
    run = 1'b1;
    n = 0;
    while (!start && n < 10) begin
      tick();
      n++;
    end
    chk("t_start", start, 1);
    wait_halted(40, n);
    chk("t_cycles", n, TMO + 1);
    chk("t_err", err, 1);
    chk("t_halted", halted, 1);
    chk("t_count", instr_count, 0);
    chk("t_pc", pc, 1);

    // Reset mid-FETCH
    clear_env();
    mem[0] = 16'h1234; mem[1] = 16'h5678; wait_tab[1] = 6;
    do_reset();
    run = 1'b1;
    n = 0;
    while (fetch_log.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("m_pre_rd", mem_rd, 1);
    chk("m_pre_count", instr_count, 1);
    rst = 1'b1;
    tick();
    chk_reset_values("m");
    do_reset();

    // Randomized programs checked against an instruction-level timing model
    for (int it = 0; it < 8; it++) begin
      clear_env();
      n_ins = $urandom_range(2, 8);
      exp_cyc = 0;
      for (int k = 0; k < n_ins; k++) begin
        w = 16'($urandom);
        if (k == n_ins - 1) w[15:13] = 3'b111;
        else if (w[15:13] == 3'b111) w[15] = 1'b0;
        mem[k] = w;
        wait_tab[k] = $urandom_range(0, 3);
        busy_tab[k] = $urandom_range(0, 4);
        if (k == n_ins - 1) exp_cyc += wait_tab[k] + 2;
        else exp_cyc += wait_tab[k] + busy_tab[k] + 5;
      end
      do_reset();
      run = 1'b1;
      n = 0;
      while (!mem_rd && n < 5) begin
        tick();
        n++;
      end
      wait_halted(500, n);
      chk($sformatf("r%0d_cycles", it), n, exp_cyc);
      chk($sformatf("r%0d_pc", it), pc, n_ins);
      chk($sformatf("r%0d_count", it), instr_count, n_ins - 1);
      chk($sformatf("r%0d_starts", it), start_cnt, n_ins - 1);
      chk($sformatf("r%0d_err", it), err, 0);
      ok = (fetch_log.size() == n_ins);
      for (int k = 0; k < fetch_log.size(); k++)
        if (fetch_log[k] != 8'(k)) ok = 1'b0;
      chk($sformatf("r%0d_fetch_order", it), ok, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
